mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Multiply/divide unit with architectural HI/LO registers for the P4 MIPS datapath. It executes mult/multu/div/divu over a fixed number of cycles and handles mthi/mtlo writes. It drives `hi`/`lo` directly into the write-back data selector, where mfhi/mflo pick them as two of its eight 32-bit inputs. It also raises `busy` so the controller stalls any further HI/LO instruction.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu (legal range 1..31).
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu (legal range 1..31).

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: issue strobe, qualified by `mdu_op`; sampled on the rising edge of `clk`.
- `mdu_op` input 4: operation code.
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 madd, 8 maddu, 9 msub, 10 msubu (only with `MDU_MADD_EN`)
  - all other codes: no-op
- `a` input 32: rs operand.
- `b` input 32: rt operand.
- `busy` output 1: a multi-cycle operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- State machine states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; a down-counter holds the cycles remaining.
- Accept condition: `start`=1 and `busy`=0 at a clock edge. When `start`=1 with `busy`=1, the unit ignores it and changes no state. Stalling is the controller's job.
- Accepting a multi-cycle op (1–4, 7–10):
  - latch `a`, `b` and the op
  - load the counter with `MULT_CYCLES` (mult class) or `DIV_CYCLES` (div class)
  - go to RUN
- In RUN, the counter decrements every cycle. On the edge where it expires:
  - write the result to `hi`/`lo`
  - return to IDLE
- mthi/mtlo:
  - accepted only in IDLE
  - `hi` (or `lo`) takes `a` on the accepting edge
  - no RUN state entered
- Arithmetic:
  - mult gives the signed 64-bit product; multu gives the unsigned 64-bit product. `hi`=[63:32], `lo`=[31:0].
  - div gives the signed quotient, truncated toward zero, in `lo`. The remainder goes to `hi` and takes the sign of the dividend.
  - divu gives the unsigned quotient in `lo` and the remainder in `hi`.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF, gives `lo`=0x80000000 and `hi`=0.
  - Divide by zero (b=0) still runs the full `DIV_CYCLES`. `hi`/`lo` remain unchanged at completion.
- The operands are latched at accept, so later changes on `a`/`b` do not affect the result.
- mfhi/mflo are not ops here. `hi`/`lo` are always readable and show the old values until completion.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, counter=0, state IDLE.
- Accept at edge E0: `busy`=1 from just after E0 through edge E_N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - At E_N, `busy` goes to 0 and the new `hi`/`lo` become visible, both in the same cycle.
  - A new `start` is accepted at E_N+1 at the earliest. `start` sampled at E_N itself sees `busy`=1 and is ignored.
- mthi/mtlo accepted at E0: the new value is visible after E0. Latency is 1 edge.
- `reset` asserted mid-RUN:
  - the pending result is discarded immediately (asynchronously)
  - all outputs take their reset values
  - the unit stays IDLE after release
- `busy` is a register output; there is no combinational path from `start`.

## Configuration
- `MDU_MADD_EN` defined: op codes 7–10 are implemented and take `MULT_CYCLES`.
  - madd: {hi,lo} ← {hi,lo} + signed(a·b)
  - maddu: {hi,lo} ← {hi,lo} + unsigned(a·b)
  - msub: {hi,lo} ← {hi,lo} − signed(a·b)
  - msubu: {hi,lo} ← {hi,lo} − unsigned(a·b)
  - The {hi,lo} accumulator base is the value at completion. It equals the value at accept, because no writes are possible while busy.
  - Arithmetic is 64-bit with wrap-around modulo 2^64.
- `MDU_MADD_EN` undefined: codes 7–10 are no-ops, exactly like other unused codes. No extra 64-bit adder is built.

## Test plan
- mult: a=0xFFFFFFFE (−2), b=3 → `busy` high for 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. Same operands with multu → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- div: a=0xFFFFFFF9 (−7), b=2 → after 10 cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu with a=7, b=2 → `lo`=3, `hi`=1.
- Corner cases:
  - div with b=0 → `busy` high for 10 cycles; `hi`/`lo` keep their prior values.
  - div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- mthi a=0x12345678 in IDLE → `hi`=0x12345678 after 1 edge, `busy` stays 0. Then start mult, and raise mtlo during busy → `lo` ends as the mult result only (mtlo ignored).
- Reset mid-op: start div and assert `reset` at cycle 4 → `busy`=0, `hi`=`lo`=0 immediately; no update after release.
- With `MDU_MADD_EN`: set `hi`=0, `lo`=0xFFFFFFFF, then maddu a=1, b=1 → `hi`=1, `lo`=0. Without the macro, the same op → no change, `busy` stays 0.

Source files
------------

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multiply/divide unit with architectural HI/LO registers
//
// Executes mult/multu/div/divu over a fixed number of cycles and handles
// mthi/mtlo writes. hi/lo feed the write-back selector directly; busy tells
// the controller to stall further HI/LO instructions.
//
// Parameters:
//   MULT_CYCLES  busy duration for the mult class (1..31)
//   DIV_CYCLES   busy duration for the div class (1..31)
// Optional feature macro:
//   MDU_MADD_EN  enables madd/maddu/msub/msubu (op codes 7..10)
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   issue strobe, qualified by mdu_op
//   mdu_op  in   [3:0] operation code
//   a       in   [31:0] rs operand
//   b       in   [31:0] rt operand
//   busy    out  multi-cycle operation in flight
//   hi      out  [31:0] HI register
//   lo      out  [31:0] LO register

module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [4:0]  count, count_n;
    logic [3:0]  op_q, op_n;
    logic [31:0] a_q, a_n;
    logic [31:0] b_q, b_n;
    logic [31:0] hi_n, lo_n;

    // Datapath operates only on the latched operands, so a/b may change freely
    // while the operation runs.
    logic        is_signed;
    logic        sa, sb;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    always_comb begin
        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
`ifdef MDU_MADD_EN
        is_signed = is_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
        sa = is_signed & a_q[31];
        sb = is_signed & b_q[31];

        // Sign/zero extension to 64 bits makes the truncated 64x64 product
        // equal to the exact signed or unsigned 64-bit product.
        prod = {{32{sa}}, a_q} * {{32{sb}}, b_q};

        // Divide on magnitudes, then restore signs: quotient truncates toward
        // zero and the remainder follows the dividend. 0x80000000 / -1 falls
        // out as quotient 0x80000000, remainder 0.
        a_mag = sa ? (32'd0 - a_q) : a_q;
        b_mag = sb ? (32'd0 - b_q) : b_q;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end else begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end
        quot = (sa ^ sb) ? (32'd0 - q_mag) : q_mag;
        rem  = sa ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_n = state;
        count_n = count;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi;
        lo_n    = lo;

        case (state)
            IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU
`ifdef MDU_MADD_EN
                        , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
                        : begin
                            state_n = RUN;
                            count_n = MULT_LOAD;
                            op_n    = mdu_op;
                            a_n     = a;
                            b_n     = b;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_n = RUN;
                            count_n = DIV_LOAD;
                            op_n    = mdu_op;
                            a_n     = a;
                            b_n     = b;
                        end
                        OP_MTHI: hi_n = a;
                        OP_MTLO: lo_n = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                count_n = count - 5'd1;
                // count==1 marks the edge where the operation completes; <=
                // also recovers if the counter were ever found at zero.
                if (count <= 5'd1) begin
                    state_n = IDLE;
                    count_n = 5'd0;
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_n, lo_n} = prod;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero leaves HI/LO untouched.
                            if (b_q != 32'd0) begin
                                hi_n = rem;
                                lo_n = quot;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU: {hi_n, lo_n} = {hi, lo} + prod;
                        OP_MSUB, OP_MSUBU: {hi_n, lo_n} = {hi, lo} - prod;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 5'd0;
            op_q  <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_n;
            count <= count_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed self-checking bench for mdu_hilo

module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int cyc;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op; cyc returns how many edges after the accept edge busy
    // stayed high (0 for single-edge ops). Operands are scrambled after accept.
    task automatic run_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                          output int n);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 4'd0;
        a      = 32'hA5A5_5A5A;
        b      = 32'h0000_0007;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
        check("mult_cycles", cyc, 5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, cyc);
        check("multu_cycles", cyc, 5);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("mult_negneg_hi", hi, 32'd0);
        check("mult_negneg_lo", lo, 32'd1);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_cycles", cyc, 10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(4'd4, 32'd7, 32'd2, cyc);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        run_op(4'd3, 32'd100, 32'd0, cyc);
        check("div0_cycles", cyc, 10);
        check("div0_lo", lo, 32'd3);
        check("div0_hi", hi, 32'd1);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        run_op(4'd5, 32'h1234_5678, 32'd0, cyc);
        check("mthi_cycles", cyc, 0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);

        // mult 0x10000 * 0x10000 = 0x1_00000000 with an mtlo held high the
        // whole time it is busy, including the completion edge.
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd1; a = 32'h0001_0000; b = 32'h0001_0000;
        @(negedge clk);
        check("mult2_busy", {31'd0, busy}, 32'd1);
        mdu_op = 4'd6; a = 32'hDEAD_BEEF;
        cyc = 0;
        while (busy && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0; mdu_op = 4'd0;
        check("mtlo_ignored_cycles", cyc, 5);
        check("mtlo_ignored_lo", lo, 32'd0);
        check("mtlo_ignored_hi", hi, 32'd1);

        // Reset four edges into a divide.
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd3; a = 32'd100; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; mdu_op = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("rst_after_busy", {31'd0, busy}, 32'd0);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);

        run_op(4'd5, 32'd0, 32'd0, cyc);
        run_op(4'd6, 32'hFFFF_FFFF, 32'd0, cyc);
        run_op(4'd8, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
        check("maddu_cycles", cyc, 5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_noop_cycles", cyc, 0);
        check("maddu_noop_hi", hi, 32'd0);
        check("maddu_noop_lo", lo, 32'hFFFF_FFFF);
`endif

        run_op(4'd15, 32'h1111_1111, 32'd1, cyc);
        check("badop_cycles", cyc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
